simd_gather_ctrl: RTL and testbench

Upstream request stage for the N-lane SIMD image memory port. It accepts one pixel-group command (row, starting column, column step) per handshake and derives N pixel addresses. It issues one read request per lane and holds each lane's address until that lane's read completes, since lane latency varies with cache hit or miss. Once every lane has returned, it presents the N gathered bytes downstream through a valid/ready handshake.

---
 rtl/simd_img_pkg.sv | 29 ++
 rtl/simd_lane_addr_gen.sv | 52 +++++
 rtl/simd_gather_ctrl.sv | 110 +++++++++++
 tb/tb_simd_gather_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_img_pkg.sv
// simd_img_pkg: image geometry, lane count and gather FSM type
// shared by the gather controller and the SIMD memory port.
package simd_img_pkg;

  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;
  localparam int N_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } gather_state_t;

  function automatic int addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

  function automatic int coord_w(input int v);
    return $clog2(v);
  endfunction

  // lane x must hold x0 + (N-1)*step without wrapping
  function automatic int lane_x_w(input int w, input int n);
    return $clog2(w) + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/simd_lane_addr_gen.sv
// simd_lane_addr_gen: one lane's x, range check and linear address.
// SIMD_GATHER_CLAMP_EN clamps out-of-range x instead of masking the lane.
module simd_lane_addr_gen
  import simd_img_pkg::*;
#(
  parameter  int IMG_W     = IMG_W_DEF,
  parameter  int IMG_H     = IMG_H_DEF,
  parameter  int N         = N_DEF,
  parameter  int LANE      = 0,
  localparam int ADDR_BITS = addr_w(IMG_W, IMG_H),
  localparam int XW        = coord_w(IMG_W),
  localparam int YW        = coord_w(IMG_H),
  localparam int LW        = lane_x_w(IMG_W, N)
) (
  input  logic [XW-1:0]        x0,
  input  logic [YW-1:0]        y,
  input  logic [XW-1:0]        step,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 mask
);

  localparam int X_MAX_I = IMG_W - 1;
  localparam int Y_MAX_I = IMG_H - 1;
  localparam logic [LW-1:0] X_MAX = X_MAX_I[LW-1:0];
  localparam logic [YW:0]   Y_MAX = Y_MAX_I[YW:0];
  localparam logic [LW-1:0] LANE_V = LANE[LW-1:0];

  logic [LW-1:0] x;
  logic [LW-1:0] xc;
  logic [YW:0]   yc;

  always_comb begin
    x    = LW'(x0) + LANE_V * LW'(step);
    yc   = {1'b0, y};
    xc   = x;
    mask = 1'b1;
    if (yc > Y_MAX) yc = Y_MAX;
    if (x > X_MAX) begin
`ifdef SIMD_GATHER_CLAMP_EN
      xc = X_MAX;
`else
      mask = 1'b0;
      xc   = '0;
`endif
    end
    addr = '0;
    if (mask)
      addr = ADDR_BITS'(yc) * ADDR_BITS'(IMG_W)
           + ADDR_BITS'(xc);
  end

endmodule

// File: rtl/simd_gather_ctrl.sv
// simd_gather_ctrl: issues N lane reads per pixel group and gathers bytes.
// Build option SIMD_GATHER_CLAMP_EN selects edge clamping in the lanes.
module simd_gather_ctrl
  import simd_img_pkg::*;
#(
  parameter  int IMG_W     = IMG_W_DEF,
  parameter  int IMG_H     = IMG_H_DEF,
  parameter  int N         = N_DEF,
  localparam int ADDR_BITS = addr_w(IMG_W, IMG_H),
  localparam int XW        = coord_w(IMG_W),
  localparam int YW        = coord_w(IMG_H)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [XW-1:0]               in_x0,
  input  logic [YW-1:0]               in_y,
  input  logic [XW-1:0]               in_step,
  output logic [N-1:0]                rd_req,
  output logic [N-1:0][ADDR_BITS-1:0] rd_addr,
  input  logic [N-1:0]                rd_valid,
  input  logic [N-1:0][7:0]           rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0][7:0]           out_data,
  output logic [N-1:0]                out_mask
);

  gather_state_t state, state_n;

  logic [N-1:0][ADDR_BITS-1:0] lane_addr;
  logic [N-1:0]                lane_mask;
  logic [N-1:0][ADDR_BITS-1:0] addr_n;
  logic [N-1:0]                mask_n;
  logic [N-1:0]                done_q, done_n;
  logic [N-1:0][7:0]           data_n;

  for (genvar i = 0; i < N; i++) begin : g_lane
    simd_lane_addr_gen #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .N     (N),
      .LANE  (i)
    ) u_lane (
      .x0   (in_x0),
      .y    (in_y),
      .step (in_step),
      .addr (lane_addr[i]),
      .mask (lane_mask[i])
    );
  end

  always_comb begin
    state_n = state;
    addr_n  = rd_addr;
    mask_n  = out_mask;
    done_n  = done_q;
    data_n  = out_data;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = ISSUE;
          addr_n  = lane_addr;
          mask_n  = lane_mask;
          done_n  = ~lane_mask;
          data_n  = '0;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        // first completion per lane wins; repeats are dropped
        for (int i = 0; i < N; i++) begin
          if (rd_valid[i] && !done_q[i]) begin
            data_n[i] = rd_data[i];
            done_n[i] = 1'b1;
          end
        end
        if (&done_n) state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rd_req    <= '0;
      rd_addr   <= '0;
      out_mask  <= '0;
      out_data  <= '0;
      done_q    <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      rd_req    <= (state_n == ISSUE) ? mask_n : '0;
      rd_addr   <= addr_n;
      out_mask  <= mask_n;
      out_data  <= data_n;
      done_q    <= done_n;
    end
  end

endmodule

// File: tb/tb_simd_gather_ctrl.sv
// tb_simd_gather_ctrl: random and directed groups vs. a lane/memory model.
// Model follows SIMD_GATHER_CLAMP_EN the same way the build does.
module tb_simd_gather_ctrl;
  import simd_img_pkg::*;

  localparam int W  = IMG_W_DEF;
  localparam int H  = IMG_H_DEF;
  localparam int N  = N_DEF;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int AB = $clog2(W * H);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [XW-1:0]        in_x0;
  logic [YW-1:0]        in_y;
  logic [XW-1:0]        in_step;
  logic [N-1:0]         rd_req;
  logic [N-1:0][AB-1:0] rd_addr;
  logic [N-1:0]         rd_valid;
  logic [N-1:0][7:0]    rd_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0][7:0]    out_data;
  logic [N-1:0]         out_mask;

  simd_gather_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x0     (in_x0),
    .in_y      (in_y),
    .in_step   (in_step),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_addr[N];
  bit exp_mask[N];
  int lat[N];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int a);
    return 8'((a * 37 + (a >> 5)) ^ 'hA5);
  endfunction

  function automatic void model(input int x0, input int y,
                                input int step);
    int yy;
    yy = (y > H - 1) ? H - 1 : y;
    for (int i = 0; i < N; i++) begin
      int x;
      x = x0 + i * step;
      exp_mask[i] = 1'b1;
      if (x > W - 1) begin
`ifdef SIMD_GATHER_CLAMP_EN
        x = W - 1;
`else
        exp_mask[i] = 1'b0;
`endif
      end
      exp_addr[i] = yy * W + x;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", 64'(in_ready), 1);
    if (!in_ready) do_reset();
  endtask

  task automatic check_addrs(input string tag);
    for (int i = 0; i < N; i++)
      if (exp_mask[i])
        chk(tag, 64'(rd_addr[i]), 64'(exp_addr[i]));
  endtask

  task automatic accept(input int x0, input int y,
                        input int step);
    wait_ready();
    in_x0    = XW'(x0);
    in_y     = YW'(y);
    in_step  = XW'(step);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_group(input int x0, input int y,
                           input int step, input bit dup,
                           input int bp);
    int                maxl;
    logic [N-1:0]      em;
    logic [N-1:0][7:0] ed;
    model(x0, y, step);
    maxl = 1;
    for (int i = 0; i < N; i++) begin
      em[i] = exp_mask[i];
      ed[i] = exp_mask[i] ? mem_byte(exp_addr[i]) : 8'h00;
      if (exp_mask[i] && lat[i] > maxl) maxl = lat[i];
    end
    accept(x0, y, step);
    chk("issue_req", 64'(rd_req), 64'(em));
    chk("issue_in_ready", 64'(in_ready), 0);
    check_addrs("issue_addr");
    rd_valid = '1;
    rd_data  = {N{8'hEE}};
    for (int c = 1; c <= maxl; c++) begin
      @(negedge clk);
      chk("wait_req", 64'(rd_req), 0);
      chk("wait_out_valid", 64'(out_valid), 0);
      check_addrs("wait_addr");
      rd_valid = '0;
      for (int i = 0; i < N; i++) begin
        if (em[i] && lat[i] == c) begin
          rd_valid[i] = 1'b1;
          rd_data[i]  = ed[i];
        end
      end
      if (dup && em[0] && c == lat[0] + 1) begin
        rd_valid[0] = 1'b1;
        rd_data[0]  = ~ed[0];
      end
    end
    for (int b = 0; b <= bp; b++) begin
      @(negedge clk);
      chk("done_valid", 64'(out_valid), 1);
      chk("done_data", 64'(out_data), 64'(ed));
      chk("done_mask", 64'(out_mask), 64'(em));
      chk("done_in_ready", 64'(in_ready), 0);
      chk("done_req", 64'(rd_req), 0);
      rd_valid = '1;
      rd_data  = {N{8'h3C}};
      if (b == bp) begin
        rd_valid  = '0;
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_valid", 64'(out_valid), 0);
    chk("idle_in_ready", 64'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x0     = '0;
    in_y      = '0;
    in_step   = '0;
    rd_valid  = '0;
    rd_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_req", 64'(rd_req), 0);
    chk("rst_mask", 64'(out_mask), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_addr", 64'(rd_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    lat = '{1, 1, 1, 1};
    run_group(10, 2, 1, 1'b0, 0);
    chk("hit_addr0", 64'(rd_addr[0]), 1034);
    chk("hit_addr3", 64'(rd_addr[3]), 1037);

    lat = '{2, 9, 5, 17};
    run_group(10, 2, 1, 1'b1, 0);

    lat = '{1, 3, 2, 4};
    run_group(510, 2, 1, 1'b0, 0);
`ifdef SIMD_GATHER_CLAMP_EN
    chk("edge_mask", 64'(out_mask), 4'b1111);
    chk("edge_addr3", 64'(rd_addr[3]), 1535);
`else
    chk("edge_mask", 64'(out_mask), 4'b0011);
    chk("edge_data", 64'(out_data[3:2]), 0);
`endif

    lat = '{3, 1, 4, 2};
    run_group(200, 300, 7, 1'b0, 5);

    model(100, 7, 3);
    accept(100, 7, 3);
    @(negedge clk);
    rd_valid = 4'b0011;
    rd_data  = {N{8'h77}};
    @(negedge clk);
    rd_valid = '0;
    @(negedge clk);
    chk("midwait_valid", 64'(out_valid), 0);
    rst = 1'b1;
    #1;
    chk("mrst_in_ready", 64'(in_ready), 1);
    chk("mrst_out_valid", 64'(out_valid), 0);
    chk("mrst_req", 64'(rd_req), 0);
    chk("mrst_mask", 64'(out_mask), 0);
    chk("mrst_data", 64'(out_data), 0);
    chk("mrst_addr", 64'(rd_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    lat = '{4, 2, 6, 1};
    run_group(33, 44, 2, 1'b1, 1);

    for (int g = 0; g < 40; g++) begin
      int x0, y, st, bp;
      bit dup;
      x0  = $urandom_range(0, W - 1);
      y   = $urandom_range(0, H - 1);
      st  = $urandom_range(0, 1) ? $urandom_range(0, 4)
                                 : $urandom_range(0, W - 1);
      dup = 1'($urandom_range(0, 1));
      bp  = $urandom_range(0, 3);
      for (int i = 0; i < N; i++)
        lat[i] = $urandom_range(1, 20);
      run_group(x0, y, st, dup, bp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
